spec_free_list: RTL and testbench
=================================

// Module: spec_free_list
// PURPOSE
//  Speculative free list feeding rename: circular queue of free physical register tags.
//  Presents the next DISPATCH_WIDTH free tags to the rename lanes every cycle.
//  Pops one tag per valid, active logical destination in the renamed bundle.
//  Accepts tags freed at commit, and recovers in a single cycle on a pipeline flush.
// PARAMETERS
//  DEPTH          64  free-list entries (SIZE_PHYSICAL_TABLE 96 - SIZE_RMT_LOG 32)
//  DISPATCH_WIDTH 4   rename lanes; pop width
//  COMMIT_WIDTH   4   freed tags per cycle; push width
//  PHY_LOG        7   physical tag width
//  LOG_REGS       32  tags 0..LOG_REGS-1 are architecturally mapped at reset
// PORTS
//  clk                in  1               clock
//  reset_n            in  1               synchronous, active-low reset
//  dispatchLaneActive_i in DISPATCH_WIDTH lane enable mask (power gating)
//  renameValid_i      in  1               bundle renamed this cycle
//  logDestValid_i     in  DISPATCH_WIDTH  per-lane valid logical destination
//  freePhys_o         out DISPATCH_WIDTH x PHY_LOG  next free tags, oldest first
//  freeListEmpty_o    out 1               stall: fewer than DISPATCH_WIDTH tags free
//  freeCount_o        out $clog2(DEPTH)+1 free entries
//  commitFree_i       in  COMMIT_WIDTH x PHY_LOG  tags released at commit
//  commitFreeValid_i  in  COMMIT_WIDTH    per-slot valid
//  recoverFlag_i      in  1               flush; restore all in-flight tags
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): entry[i]=LOG_REGS+i; head=tail=0; count=DEPTH.
//    freeListEmpty_o=0; freeCount_o=DEPTH; freePhys_o[k]=LOG_REGS+k.
//  - Read: freePhys_o[k]=entry[(head+k) mod DEPTH]. Register-sourced, zero latency.
//    Rename lane n uses slot = number of valid destinations in lanes < n.
//  - Pop: nPop=popcount(logDestValid_i & dispatchLaneActive_i).
//    Applied only when renameValid_i=1 and freeListEmpty_o=0.
//    Effect: head+=nPop, count-=nPop.
//    If freeListEmpty_o=1 the pop is ignored. Upstream must hold the bundle.
//  - Push: valid commitFree_i slots are compacted in slot order into entry[tail], entry[tail+1], ...
//    Invalid slots are skipped. tail+=nPush, count+=nPush.
//  - Same cycle push and pop: count_next = count - nPop + nPush. Both pointers update independently.
//  - Pointer arithmetic: wrap with the explicit test (ptr+n >= DEPTH) ? ptr+n-DEPTH : ptr+n.
//    DEPTH need not be a power of 2. Count width is $clog2(DEPTH)+1.
//  - freeListEmpty_o is registered: next value = (count_next < DISPATCH_WIDTH).
//    count==DISPATCH_WIDTH exactly gives 0.
//  - Recovery (recoverFlag_i=1): pushes that cycle are still written and tail advances.
//    head_next=tail_next; count=DEPTH; any pop is ignored.
//    Entries in [tail,head) hold exactly the in-flight destinations, so they become free again.
//  - Recovery has priority over pop. Reset has priority over everything.
//  - Illegal (simulation assertion, no RTL guard):
//    * count - nPop + nPush > DEPTH.
//    * nPop > count.
//    * X on any valid input.
// STRUCTURE
//  - Package: DEPTH, PHY_LOG, LOG_REGS constants; phys_tag_t typedef; count_t typedef.
//  - One sub-module, fl_ptr_add: modular add of pointer + n (n <= max width), used for head and tail.
//  - Storage: flop array DEPTH x PHY_LOG.
//    Write path: COMMIT_WIDTH compaction muxes with per-slot prefix-count offsets.
//    Read path: DISPATCH_WIDTH read muxes.
// TESTING
//  1. Reset, idle -> freePhys_o={32,33,34,35}; freeCount_o=64; freeListEmpty_o=0.
//  2. Rename logDestValid=4'b0101, all lanes active -> next cycle head=2; freePhys_o={34,35,36,37}; count=62.
//  3. 16 bundles of 4 pops with no pushes -> count=0, freeListEmpty_o=1.
//     A further pop request -> no change.
//     Then push {40,41,42,43} -> count=4, freeListEmpty_o=0 next cycle.
//  4. Wrap: head=62, pop 4 -> head=2; freePhys_o[0]=entry[2].
//     Tail=63 push 3 -> writes 63,0,1; tail=2.
//  5. Same cycle: pop 3 with commitFreeValid=4'b1010 (tags 50,51) -> count-=1.
//     Writes entry[tail]=50, entry[tail+1]=51.
//  6. After 10 pops and 4 pushes, recoverFlag_i with 2 valid pushes -> head=tail (after push); count=64.
//     freePhys_o shows the oldest in-flight tags.

Source files
------------

// File: rtl/spec_free_list_pkg.sv
// Shared constants, tag/count types and helpers for the speculative free list.
// Imported by the interface, the pointer adder user and the top.
package spec_free_list_pkg;

  localparam int DEPTH          = 64;
  localparam int DISPATCH_WIDTH = 4;
  localparam int COMMIT_WIDTH   = 4;
  localparam int PHY_LOG        = 7;
  localparam int LOG_REGS       = 32;

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int SLOT_W = (DISPATCH_WIDTH > COMMIT_WIDTH) ?
                          DISPATCH_WIDTH : COMMIT_WIDTH;
  localparam int SCNT_W = $clog2(SLOT_W + 1);

  typedef logic [PHY_LOG-1:0] phys_tag_t;
  typedef logic [CNT_W-1:0]   count_t;
  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [SCNT_W-1:0]  slot_cnt_t;

  typedef struct packed {
    ptr_t   head;
    ptr_t   tail;
    count_t count;
    logic   empty;
  } fl_state_t;

  function automatic slot_cnt_t ones(input logic [SLOT_W-1:0] v);
    slot_cnt_t c;
    c = '0;
    for (int i = 0; i < SLOT_W; i++) begin
      c = c + slot_cnt_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/spec_free_list_if.sv
// Rename/commit side bundle of the free list: lane masks, free tags out,
// commit-freed tags in, flush. master = rename/commit, slave = free list.
interface spec_free_list_if;
  import spec_free_list_pkg::*;

  logic [DISPATCH_WIDTH-1:0]            dispatchLaneActive_i;
  logic                                 renameValid_i;
  logic [DISPATCH_WIDTH-1:0]            logDestValid_i;
  phys_tag_t [DISPATCH_WIDTH-1:0]       freePhys_o;
  logic                                 freeListEmpty_o;
  count_t                               freeCount_o;
  phys_tag_t [COMMIT_WIDTH-1:0]         commitFree_i;
  logic [COMMIT_WIDTH-1:0]              commitFreeValid_i;
  logic                                 recoverFlag_i;

  modport master (
    output dispatchLaneActive_i,
    output renameValid_i,
    output logDestValid_i,
    input  freePhys_o,
    input  freeListEmpty_o,
    input  freeCount_o,
    output commitFree_i,
    output commitFreeValid_i,
    output recoverFlag_i
  );

  modport slave (
    input  dispatchLaneActive_i,
    input  renameValid_i,
    input  logDestValid_i,
    output freePhys_o,
    output freeListEmpty_o,
    output freeCount_o,
    input  commitFree_i,
    input  commitFreeValid_i,
    input  recoverFlag_i
  );

endinterface

// File: rtl/fl_ptr_add.sv
// Modular pointer add: sum = (ptr + n) mod DEPTH, DEPTH need not be 2^k.
// Ports: ptr (current pointer), n (small advance), sum (wrapped result).
module fl_ptr_add #(
  parameter int DEPTH = 64,
  parameter int PTR_W = 6,
  parameter int N_W   = 3
) (
  input  logic [PTR_W-1:0] ptr,
  input  logic [N_W-1:0]   n,
  output logic [PTR_W-1:0] sum
);

  logic [PTR_W:0] raw;

  assign raw = {1'b0, ptr} + (PTR_W+1)'(n);

  // n never exceeds DEPTH, so one conditional subtract wraps fully.
  assign sum = (raw >= (PTR_W+1)'(DEPTH)) ?
               PTR_W'(raw - (PTR_W+1)'(DEPTH)) :
               raw[PTR_W-1:0];

endmodule

// File: rtl/spec_free_list.sv
// Speculative free list: circular queue of free physical tags for rename.
// Ports: clk, reset_n (sync, active-low), bus (spec_free_list_if.slave).
module spec_free_list
  import spec_free_list_pkg::*;
(
  input logic             clk,
  input logic             reset_n,
  spec_free_list_if.slave bus
);

  phys_tag_t mem [DEPTH];

  fl_state_t s_q;
  fl_state_t s_d;

  logic [DISPATCH_WIDTH-1:0] pop_mask;
  slot_cnt_t                 n_pop;
  slot_cnt_t                 n_pop_eff;
  slot_cnt_t                 n_push;
  slot_cnt_t                 off [COMMIT_WIDTH];
  ptr_t                      wr_addr [COMMIT_WIDTH];
  ptr_t                      rd_addr [DISPATCH_WIDTH];
  ptr_t                      head_adv;
  ptr_t                      tail_nx;
  logic                      pop_en;
  logic [CNT_W:0]            cnt_wide;

  assign pop_mask  = bus.logDestValid_i & bus.dispatchLaneActive_i;
  assign n_pop     = ones(SLOT_W'(pop_mask));
  assign n_push    = ones(SLOT_W'(bus.commitFreeValid_i));

  // A stalled bundle is held upstream; a flush discards it.
  assign pop_en    = bus.renameValid_i & ~s_q.empty & ~bus.recoverFlag_i;
  assign n_pop_eff = pop_en ? n_pop : '0;

  // Prefix count of valid slots gives each freed tag its compacted offset.
  always_comb begin
    slot_cnt_t run;
    run = '0;
    for (int s = 0; s < COMMIT_WIDTH; s++) begin
      off[s] = run;
      run    = run + slot_cnt_t'(bus.commitFreeValid_i[s]);
    end
  end

  fl_ptr_add #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .N_W   (SCNT_W)
  ) u_head_add (
    .ptr (s_q.head),
    .n   (n_pop_eff),
    .sum (head_adv)
  );

  fl_ptr_add #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .N_W   (SCNT_W)
  ) u_tail_add (
    .ptr (s_q.tail),
    .n   (n_push),
    .sum (tail_nx)
  );

  for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_rd
    fl_ptr_add #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .N_W   (SCNT_W)
    ) u_rd_add (
      .ptr (s_q.head),
      .n   (slot_cnt_t'(k)),
      .sum (rd_addr[k])
    );
    assign bus.freePhys_o[k] = mem[rd_addr[k]];
  end

  for (genvar s = 0; s < COMMIT_WIDTH; s++) begin : g_wr
    fl_ptr_add #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .N_W   (SCNT_W)
    ) u_wr_add (
      .ptr (s_q.tail),
      .n   (off[s]),
      .sum (wr_addr[s])
    );
  end

  assign cnt_wide = {1'b0, s_q.count}
                  - (CNT_W+1)'(n_pop_eff)
                  + (CNT_W+1)'(n_push);

  always_comb begin
    s_d      = s_q;
    s_d.tail = tail_nx;
    if (bus.recoverFlag_i) begin
      // Everything between tail and head is in flight: hand it all back.
      s_d.head  = tail_nx;
      s_d.count = count_t'(DEPTH);
    end else begin
      s_d.head  = head_adv;
      s_d.count = cnt_wide[CNT_W-1:0];
    end
    s_d.empty = s_d.count < count_t'(DISPATCH_WIDTH);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_q.head  <= '0;
      s_q.tail  <= '0;
      s_q.count <= count_t'(DEPTH);
      s_q.empty <= 1'b0;
    end else begin
      s_q <= s_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= phys_tag_t'(LOG_REGS + i);
      end
    end else begin
      for (int s = 0; s < COMMIT_WIDTH; s++) begin
        if (bus.commitFreeValid_i[s]) begin
          mem[wr_addr[s]] <= bus.commitFree_i[s];
        end
      end
    end
  end

  assign bus.freeCount_o     = s_q.count;
  assign bus.freeListEmpty_o = s_q.empty;

  phys_tag_t [COMMIT_WIDTH-1:0] live_tags;

  always_comb begin
    live_tags = '0;
    for (int s = 0; s < COMMIT_WIDTH; s++) begin
      live_tags[s] = bus.commitFreeValid_i[s] ?
                     bus.commitFree_i[s] : '0;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset_n)
    !bus.recoverFlag_i |-> cnt_wide <= (CNT_W+1)'(DEPTH)
  );

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!reset_n)
    pop_en |-> count_t'(n_pop) <= s_q.count
  );

  a_no_x: assert property (
    @(posedge clk) disable iff (!reset_n)
    !$isunknown({bus.renameValid_i, bus.recoverFlag_i,
                 bus.commitFreeValid_i, live_tags,
                 bus.renameValid_i ? pop_mask : '0})
  );

endmodule

// File: tb/tb_spec_free_list.sv
// Directed bench for spec_free_list with a queue scoreboard.
// Driver pushes hand-computed next-cycle state; monitor compares after posedge.
module tb_spec_free_list;
  import spec_free_list_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  spec_free_list_if fl_if();

  spec_free_list dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (fl_if)
  );

  typedef struct {
    string nm;
    int    t0;
    int    t1;
    int    t2;
    int    t3;
    int    cnt;
    int    emp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input int req);
    n_run++;
    if (act !== 32'(req)) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk({mon_e.nm, ".tag0"}, 32'(fl_if.freePhys_o[0]), mon_e.t0);
      chk({mon_e.nm, ".tag1"}, 32'(fl_if.freePhys_o[1]), mon_e.t1);
      chk({mon_e.nm, ".tag2"}, 32'(fl_if.freePhys_o[2]), mon_e.t2);
      chk({mon_e.nm, ".tag3"}, 32'(fl_if.freePhys_o[3]), mon_e.t3);
      chk({mon_e.nm, ".count"}, 32'(fl_if.freeCount_o), mon_e.cnt);
      chk({mon_e.nm, ".empty"}, 32'(fl_if.freeListEmpty_o), mon_e.emp);
    end
  end

  task automatic drive(input bit rv, input logic [3:0] ldv,
                       input logic [3:0] act, input logic [3:0] cfv,
                       input int c0, input int c1, input int c2,
                       input int c3, input bit rec);
    fl_if.renameValid_i        = rv;
    fl_if.logDestValid_i       = ldv;
    fl_if.dispatchLaneActive_i = act;
    fl_if.commitFreeValid_i    = cfv;
    fl_if.commitFree_i[0]      = phys_tag_t'(c0);
    fl_if.commitFree_i[1]      = phys_tag_t'(c1);
    fl_if.commitFree_i[2]      = phys_tag_t'(c2);
    fl_if.commitFree_i[3]      = phys_tag_t'(c3);
    fl_if.recoverFlag_i        = rec;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 4'hF, 4'h0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic expect_nx(input string nm, input int t0, input int t1,
                           input int t2, input int t3, input int cnt,
                           input int emp);
    sb.push_back('{nm, t0, t1, t2, t3, cnt, emp});
    @(negedge clk);
  endtask

  initial begin
    int h;
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    idle();
    expect_nx("reset", 32, 33, 34, 35, 64, 0);

    drive(1'b1, 4'b0101, 4'hF, 4'h0, 0, 0, 0, 0, 1'b0);
    expect_nx("pop2", 34, 35, 36, 37, 62, 0);

    drive(1'b1, 4'b1111, 4'b0011, 4'h0, 0, 0, 0, 0, 1'b0);
    expect_nx("lanemask", 36, 37, 38, 39, 60, 0);

    drive(1'b0, 4'b1111, 4'hF, 4'h0, 0, 0, 0, 0, 1'b0);
    expect_nx("norename", 36, 37, 38, 39, 60, 0);

    for (int j = 0; j < 15; j++) begin
      h = (8 + 4 * j) % 64;
      drive(1'b1, 4'b1111, 4'hF, 4'h0, 0, 0, 0, 0, 1'b0);
      expect_nx($sformatf("drain%0d", j), 32 + h, 33 + h, 34 + h,
                35 + h, 56 - 4 * j, (j == 14) ? 1 : 0);
    end

    drive(1'b1, 4'b1111, 4'hF, 4'h0, 0, 0, 0, 0, 1'b0);
    expect_nx("emptyhold", 32, 33, 34, 35, 0, 1);

    drive(1'b0, 4'h0, 4'hF, 4'hF, 40, 41, 42, 43, 1'b0);
    expect_nx("refill", 40, 41, 42, 43, 4, 0);

    for (int j = 0; j < 14; j++) begin
      drive(1'b1, 4'b1111, 4'hF, 4'hF, 36 + 4 * j, 37 + 4 * j,
            38 + 4 * j, 39 + 4 * j, 1'b0);
      expect_nx($sformatf("stream%0d", j), 36 + 4 * j, 37 + 4 * j,
                38 + 4 * j, 39 + 4 * j, 4, 0);
    end

    drive(1'b1, 4'b0111, 4'hF, 4'b0111, 92, 93, 94, 0, 1'b0);
    expect_nx("pp3", 91, 92, 93, 94, 4, 0);

    drive(1'b0, 4'h0, 4'hF, 4'b1110, 0, 110, 111, 112, 1'b0);
    expect_nx("tailwrap", 91, 92, 93, 94, 7, 0);

    drive(1'b1, 4'b0111, 4'hF, 4'h0, 0, 0, 0, 0, 1'b0);
    expect_nx("readwrap", 94, 110, 111, 112, 4, 0);

    drive(1'b1, 4'b1111, 4'hF, 4'h0, 0, 0, 0, 0, 1'b0);
    expect_nx("headwrap", 42, 43, 36, 37, 0, 1);

    drive(1'b0, 4'h0, 4'hF, 4'hF, 60, 61, 62, 63, 1'b0);
    expect_nx("push4", 60, 61, 62, 63, 4, 0);

    drive(1'b1, 4'b0111, 4'hF, 4'b1010, 120, 50, 121, 51, 1'b0);
    expect_nx("pushpop", 63, 50, 51, 40, 3, 1);

    drive(1'b0, 4'h0, 4'hF, 4'hF, 70, 71, 72, 73, 1'b0);
    expect_nx("fill_a", 63, 50, 51, 70, 7, 0);

    drive(1'b0, 4'h0, 4'hF, 4'hF, 74, 75, 76, 77, 1'b0);
    expect_nx("fill_b", 63, 50, 51, 70, 11, 0);

    drive(1'b1, 4'b1111, 4'hF, 4'hF, 80, 81, 82, 83, 1'b0);
    expect_nx("inflight_a", 71, 72, 73, 74, 11, 0);

    drive(1'b1, 4'b1111, 4'hF, 4'h0, 0, 0, 0, 0, 1'b0);
    expect_nx("inflight_b", 75, 76, 77, 80, 7, 0);

    drive(1'b1, 4'b1001, 4'hF, 4'h0, 0, 0, 0, 0, 1'b0);
    expect_nx("inflight_c", 77, 80, 81, 82, 5, 0);

    drive(1'b1, 4'b1111, 4'hF, 4'b0110, 0, 90, 91, 0, 1'b1);
    expect_nx("recover", 54, 55, 56, 57, 64, 0);

    drive(1'b1, 4'b0001, 4'hF, 4'h0, 0, 0, 0, 0, 1'b0);
    expect_nx("postrec", 55, 56, 57, 58, 63, 0);

    reset_n = 1'b0;
    idle();
    expect_nx("rereset", 32, 33, 34, 35, 64, 0);

    reset_n = 1'b1;
    drive(1'b1, 4'b0001, 4'hF, 4'h0, 0, 0, 0, 0, 1'b0);
    expect_nx("rr_pop1", 33, 34, 35, 36, 63, 0);

    drive(1'b0, 4'h0, 4'hF, 4'h0, 0, 0, 0, 0, 1'b1);
    expect_nx("rr_recover", 32, 33, 34, 35, 64, 0);

    idle();
    @(negedge clk);
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
